// File: rtl/pipe_sel_mux_if.sv
// pipe_sel_mux_if: bundles the data, select and hazard-control inputs and the
// registered outputs of pipe_sel_mux.
//   master : drives data_i/select_i/valid_i/stall_i/flush_i, reads outputs
//   slave  : the mux itself
interface pipe_sel_mux_if #(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]        select_i;
    logic                    valid_i;
    logic                    stall_i;
    logic                    flush_i;
    logic [WIDTH-1:0]        data_o;
    logic                    valid_o;
    logic                    sel_err_o;
    logic [15:0]             err_cnt_o;

    modport master (
        output data_i, select_i, valid_i, stall_i, flush_i,
        input  data_o, valid_o, sel_err_o, err_cnt_o
    );

    modport slave (
        input  data_i, select_i, valid_i, stall_i, flush_i,
        output data_o, valid_o, sel_err_o, err_cnt_o
    );
endinterface

// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: NUM_IN-way WIDTH-bit select mux feeding a STAGES-deep register
// pipeline with valid, stall (hold) and flush; latency is STAGES cycles.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset (beats flush and stall)
//   bus.data_i     packed inputs, input k = data_i[k*WIDTH +: WIDTH]
//   bus.select_i   input index; >= NUM_IN picks input 0 and flags an error
//   bus.valid_i    input beat qualifier
//   bus.stall_i    hold every stage, input beat not captured
//   bus.flush_i    clear every stage to zero, input beat dropped
//   bus.data_o     selected data, STAGES cycles later
//   bus.valid_o    valid aligned with data_o
//   bus.sel_err_o  beat on data_o had an out-of-range select
//   bus.err_cnt_o  saturating out-of-range count
// Build option: define PIPE_SEL_MUX_ERR_CNT_EN to build the 16-bit saturating
// error counter; otherwise err_cnt_o is tied to zero.
module pipe_sel_mux #(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = 2,
    parameter int STAGES = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pipe_sel_mux_if.slave bus
);

    // Stage 0: combinational selection. An unmatched select falls through
    // to the input-0 default with the error flag still set.
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    always_comb begin
        sel_data = bus.data_i[WIDTH-1:0];
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.select_i == SEL_W'(k)) begin
                sel_data = bus.data_i[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    // Shift pipeline. Reset and flush have the same effect on the stages;
    // they differ only for the error counter below.
    logic [WIDTH-1:0]  stg_data [STAGES];
    logic [STAGES-1:0] stg_vld;
    logic [STAGES-1:0] stg_err;

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            for (int s = 0; s < STAGES; s++) begin
                stg_data[s] <= '0;
            end
            stg_vld <= '0;
            stg_err <= '0;
        end else if (!bus.stall_i) begin
            stg_data[0] <= sel_data;
            stg_vld[0]  <= bus.valid_i;
            stg_err[0]  <= sel_err;
            for (int s = 1; s < STAGES; s++) begin
                stg_data[s] <= stg_data[s-1];
                stg_vld[s]  <= stg_vld[s-1];
                stg_err[s]  <= stg_err[s-1];
            end
        end
    end

    assign bus.data_o    = stg_data[STAGES-1];
    assign bus.valid_o   = stg_vld[STAGES-1];
    assign bus.sel_err_o = stg_err[STAGES-1];

`ifdef PIPE_SEL_MUX_ERR_CNT_EN
    // Counts accepted valid beats with a bad select; survives flush so the
    // hazard unit cannot hide errors.
    logic [15:0] err_cnt;
    logic        cnt_inc;

    assign cnt_inc = bus.valid_i && sel_err && !bus.stall_i &&
                     !bus.flush_i && (err_cnt != 16'hFFFF);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (cnt_inc) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign bus.err_cnt_o = err_cnt;
`else
    assign bus.err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// tb_pipe_sel_mux: directed and random stimulus for pipe_sel_mux with a
// queue-based scoreboard and a separate output monitor.
module tb_pipe_sel_mux;

    localparam int NUM_IN = 3;
    localparam int WIDTH  = 32;
    localparam int SEL_W  = 2;
    localparam int STAGES = 3;

`ifdef PIPE_SEL_MUX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    pipe_sel_mux_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    pipe_sel_mux #(
        .NUM_IN(NUM_IN), .WIDTH(WIDTH), .SEL_W(SEL_W), .STAGES(STAGES)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             vld;
        logic             err;
    } beat_t;

    beat_t       exp_q[$];
    int          zeros_ahead = STAGES;
    int          ev = 2;
    int unsigned cnt_model = 0;
    int          checks = 0;
    int          failures = 0;

    logic [WIDTH-1:0] prev_data;
    logic             prev_vld;
    logic             prev_err;
    logic [15:0]      prev_cnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Reference model: what the spec says happens to the stream on each edge.
    // ev: 0 = hold, 1 = shift, 2 = cleared (reset or flush).
    always @(posedge clk_i) begin
        beat_t b;
        int    idx;
        if (rst_i) begin
            exp_q.delete();
            zeros_ahead = STAGES;
            cnt_model   = 0;
            ev          = 2;
        end else if (bus.flush_i) begin
            exp_q.delete();
            zeros_ahead = STAGES;
            ev          = 2;
        end else if (bus.stall_i) begin
            ev = 0;
        end else begin
            idx = int'(bus.select_i);
            if (idx < NUM_IN) begin
                b.data = bus.data_i[idx*WIDTH +: WIDTH];
                b.err  = 1'b0;
            end else begin
                b.data = bus.data_i[WIDTH-1:0];
                b.err  = 1'b1;
            end
            b.vld = bus.valid_i;
            exp_q.push_back(b);
            if (zeros_ahead > 0) zeros_ahead--;
            if (b.vld && b.err && cnt_model < 65535) cnt_model++;
            ev = 1;
        end
    end

    // Monitor: looks at the outputs just after each edge.
    always @(posedge clk_i) begin
        beat_t b;
        #1;
        if (ev == 0) begin
            chk("hold_data", 64'(bus.data_o), 64'(prev_data));
            chk("hold_valid", 64'(bus.valid_o), 64'(prev_vld));
            chk("hold_err", 64'(bus.sel_err_o), 64'(prev_err));
            chk("hold_cnt", 64'(bus.err_cnt_o), 64'(prev_cnt));
        end else if (zeros_ahead > 0) begin
            chk("clr_data", 64'(bus.data_o), 64'd0);
            chk("clr_valid", 64'(bus.valid_o), 64'd0);
            chk("clr_err", 64'(bus.sel_err_o), 64'd0);
        end else if (exp_q.size() == 0) begin
            chk("sb_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            b = exp_q.pop_front();
            chk("out_valid", 64'(bus.valid_o), 64'(b.vld));
            chk("out_data", 64'(bus.data_o), 64'(b.data));
            chk("out_err", 64'(bus.sel_err_o), 64'(b.err));
        end
        chk("err_cnt", 64'(bus.err_cnt_o),
            CNT_EN ? 64'(cnt_model) : 64'd0);
        prev_data = bus.data_o;
        prev_vld  = bus.valid_o;
        prev_err  = bus.sel_err_o;
        prev_cnt  = bus.err_cnt_o;
    end

    task automatic cyc(input logic [SEL_W-1:0] s, input logic v,
                       input logic st, input logic fl, input logic rs);
        @(negedge clk_i);
        bus.select_i = s;
        bus.valid_i  = v;
        bus.stall_i  = st;
        bus.flush_i  = fl;
        rst_i        = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_data();
        bus.data_i = {$urandom, $urandom, $urandom};
    endtask

    initial begin
        bus.data_i   = '0;
        bus.select_i = '0;
        bus.valid_i  = 1'b0;
        bus.stall_i  = 1'b0;
        bus.flush_i  = 1'b0;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // selection of each in-range input
        bus.data_i = {32'h33, 32'h22, 32'h11};
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(2, 1, 0, 0, 0);
        idle(4);

        // out-of-range select
        cyc(3, 1, 0, 0, 0);
        idle(4);

        // stall for two cycles after B is captured
        rand_data(); cyc(0, 1, 0, 0, 0);
        rand_data(); cyc(1, 1, 0, 0, 0);
        rand_data(); cyc(2, 1, 1, 0, 0);
        cyc(2, 1, 1, 0, 0);
        rand_data(); cyc(2, 1, 0, 0, 0);
        idle(5);

        // flush a full pipeline, then resume
        for (int i = 0; i < 3; i++) begin
            rand_data(); cyc(SEL_W'(i), 1, 0, 0, 0);
        end
        rand_data(); cyc(1, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            rand_data(); cyc(SEL_W'(i % 4), 1, 0, 0, 0);
        end

        // stall and flush together, then reset mid-stream
        rand_data(); cyc(3, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            rand_data(); cyc(SEL_W'(3 - i), 1, 0, 0, 0);
        end
        rand_data(); cyc(3, 1, 0, 0, 1);
        idle(4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            cyc(SEL_W'($urandom_range(3, 0)),
                $urandom_range(3, 0) != 0,
                $urandom_range(99, 0) < 15,
                $urandom_range(99, 0) < 5,
                $urandom_range(99, 0) < 1);
        end

        // counter saturation (or staying at zero without the counter)
        cyc(0, 0, 0, 0, 1);
        if (CNT_EN) begin
            for (int i = 0; i < 70000; i++) cyc(3, 1, 0, 0, 0);
        end else begin
            for (int i = 0; i < 300; i++) cyc(3, 1, 0, 0, 0);
        end
        idle(STAGES + 2);
        if (CNT_EN) chk("cnt_sat", 64'(bus.err_cnt_o), 64'hFFFF);
        else        chk("cnt_off", 64'(bus.err_cnt_o), 64'h0);

        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
